// File: rtl/mcu_packet_assembler.sv
// Assembles SPI-slave bytes into NDN interest/data packets with one-cycle RX_valid/frame_error.
// Optional MCU_ASM_LEN_CHECK_EN rejects interest packets whose meta length is 0 or > PREFIX_BYTES.
module mcu_packet_assembler #(
  parameter int unsigned PREFIX_BYTES = 8,
  parameter int unsigned DATA_BYTES   = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ss,
  input  logic [7:0]                byte_in,
  input  logic                      byte_valid,
  output logic                      RX_valid,
  output logic [7:0]                packet_meta_data,
  output logic [8*PREFIX_BYTES-1:0] packet_prefix,
  output logic [8*DATA_BYTES-1:0]   packet_data,
  output logic                      frame_error
);

  localparam int unsigned PrefixW   = 8 * PREFIX_BYTES;
  localparam int unsigned DataW     = 8 * DATA_BYTES;
  localparam logic [5:0]  PrefixLen = 6'(PREFIX_BYTES);
  localparam logic [5:0]  DataLen   = 6'(DATA_BYTES);

  typedef enum logic [1:0] {StIdle, StHdr, StBody, StErrWait} state_e;

  state_e               state_q, state_d;
  logic                 ss_prev_q;
  logic [5:0]           cnt_q, cnt_d;
  logic [7:0]           meta_sh_q, meta_sh_d;
  logic [PrefixW-1:0]   prefix_sh_q, prefix_sh_d;
  logic [DataW-1:0]     data_sh_q, data_sh_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_error_q, frame_error_d;
  logic [7:0]           meta_q, meta_d;
  logic [PrefixW-1:0]   prefix_q, prefix_d;
  logic [DataW-1:0]     data_q, data_d;

  logic                 ss_fall;
  logic                 overflow;
  logic                 len_bad;
  logic                 accept;
  logic                 reject;
  logic [5:0]           exp_len;

  // ss_prev resets low so a frame already open at reset release is never seen as a falling edge.
  assign ss_fall = ss_prev_q & ~ss;
  assign exp_len = meta_sh_d[6] ? PrefixLen : DataLen;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (ss_fall) state_d = StHdr;
      StHdr:     if (ss) state_d = StIdle; else if (byte_valid) state_d = StBody;
      StBody:    if (ss) state_d = StIdle; else if (overflow) state_d = StErrWait;
      StErrWait: if (ss) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Byte absorb happens before the close decision so a byte coincident with ss rising counts.
  always_comb begin
    cnt_d       = cnt_q;
    meta_sh_d   = meta_sh_q;
    prefix_sh_d = prefix_sh_q;
    data_sh_d   = data_sh_q;
    overflow    = 1'b0;
    unique case (state_q)
      StIdle: if (ss_fall) cnt_d = '0;
      StHdr:  if (byte_valid) meta_sh_d = byte_in;
      StBody: begin
        if (byte_valid) begin
          if (cnt_q == exp_len) begin
            overflow = 1'b1;
          end else begin
            if (meta_sh_q[6]) prefix_sh_d = {prefix_sh_q[PrefixW-9:0], byte_in};
            else              data_sh_d   = {data_sh_q[DataW-9:0], byte_in};
            if (cnt_q != 6'h3f) cnt_d = cnt_q + 6'd1;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    len_bad = 1'b0;
`ifdef MCU_ASM_LEN_CHECK_EN
    len_bad = meta_sh_d[6] && ((meta_sh_d[5:0] == 6'd0) || (meta_sh_d[5:0] > PrefixLen));
`endif
    accept = ss && ((state_q == StHdr) || (state_q == StBody)) && !overflow &&
             (cnt_d == exp_len) && !len_bad;
    reject = ss && (state_q != StIdle) && !accept;

    rx_valid_d    = accept;
    frame_error_d = reject;
    meta_d        = accept ? meta_sh_d : meta_q;
    prefix_d      = (accept && meta_sh_d[6])  ? prefix_sh_d : prefix_q;
    data_d        = (accept && !meta_sh_d[6]) ? data_sh_d   : data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ss_prev_q     <= 1'b0;
      cnt_q         <= '0;
      meta_sh_q     <= '0;
      prefix_sh_q   <= '0;
      data_sh_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_error_q <= 1'b0;
      meta_q        <= '0;
      prefix_q      <= '0;
      data_q        <= '0;
    end else begin
      ss_prev_q     <= ss;
      cnt_q         <= cnt_d;
      meta_sh_q     <= meta_sh_d;
      prefix_sh_q   <= prefix_sh_d;
      data_sh_q     <= data_sh_d;
      rx_valid_q    <= rx_valid_d;
      frame_error_q <= frame_error_d;
      meta_q        <= meta_d;
      prefix_q      <= prefix_d;
      data_q        <= data_d;
    end
  end

  assign RX_valid         = rx_valid_q;
  assign frame_error      = frame_error_q;
  assign packet_meta_data = meta_q;
  assign packet_prefix    = prefix_q;
  assign packet_data      = data_q;

endmodule

// File: tb/tb_mcu_packet_assembler.sv
// Directed self-checking bench for mcu_packet_assembler; inputs driven and outputs sampled on negedge.
module tb_mcu_packet_assembler;

  logic         clk;
  logic         rst;
  logic         ss;
  logic [7:0]   byte_in;
  logic         byte_valid;
  logic         rx_valid;
  logic [7:0]   meta;
  logic [63:0]  prefix;
  logic [255:0] data;
  logic         frame_error;

  int tests = 0;
  int fails = 0;

  localparam logic [63:0]  Pfx1  = 64'h0102030405060708;
  localparam logic [63:0]  Pfx2  = 64'h1112131415161718;
  localparam logic [63:0]  Pfx3  = 64'h2122232425262728;
  localparam logic [255:0] Data1 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  mcu_packet_assembler dut (
    .clk              (clk),
    .rst              (rst),
    .ss               (ss),
    .byte_in          (byte_in),
    .byte_valid       (byte_valid),
    .RX_valid         (rx_valid),
    .packet_meta_data (meta),
    .packet_prefix    (prefix),
    .packet_data      (data),
    .frame_error      (frame_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the following posedge sees the falling edge of ss.
  task automatic open_frame();
    ss = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_seq(input logic [7:0] start, input int n, input bit close_last);
    for (int i = 0; i < n; i++) begin
      byte_in    = start + 8'(i);
      byte_valid = 1'b1;
      if (close_last && (i == n - 1)) ss = 1'b1;
      @(negedge clk);
      byte_valid = 1'b0;
    end
  endtask

  task automatic close_frame();
    ss = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst        = 1'b1;
    ss         = 1'b1;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_rx",     {255'd0, rx_valid}, 256'd0);
    check("reset_err",    {255'd0, frame_error}, 256'd0);
    check("reset_meta",   {248'd0, meta}, 256'd0);
    check("reset_prefix", {192'd0, prefix}, 256'd0);
    check("reset_data",   data, 256'd0);
    rst = 1'b0;
    @(negedge clk);

    // Valid interest frame
    open_frame();
    send_seq(8'h48, 1, 1'b0);
    send_seq(8'h01, 8, 1'b0);
    check("int_no_early_rx", {255'd0, rx_valid}, 256'd0);
    close_frame();
    check("int_rx",     {255'd0, rx_valid}, 256'd1);
    check("int_err",    {255'd0, frame_error}, 256'd0);
    check("int_meta",   {248'd0, meta}, 256'h48);
    check("int_prefix", {192'd0, prefix}, {192'd0, Pfx1});
    check("int_data",   data, 256'd0);
    @(negedge clk);
    check("int_rx_pulse",     {255'd0, rx_valid}, 256'd0);
    check("int_prefix_stable", {192'd0, prefix}, {192'd0, Pfx1});

    // Valid data frame
    open_frame();
    send_seq(8'h00, 1, 1'b0);
    send_seq(8'h00, 32, 1'b0);
    close_frame();
    check("dat_rx",     {255'd0, rx_valid}, 256'd1);
    check("dat_meta",   {248'd0, meta}, 256'h00);
    check("dat_data",   data, Data1);
    check("dat_prefix", {192'd0, prefix}, {192'd0, Pfx1});
    @(negedge clk);

    // Short interest frame
    open_frame();
    send_seq(8'h48, 1, 1'b0);
    send_seq(8'hA0, 5, 1'b0);
    close_frame();
    check("short_err",    {255'd0, frame_error}, 256'd1);
    check("short_rx",     {255'd0, rx_valid}, 256'd0);
    check("short_meta",   {248'd0, meta}, 256'h00);
    check("short_prefix", {192'd0, prefix}, {192'd0, Pfx1});
    check("short_data",   data, Data1);
    @(negedge clk);
    check("short_err_pulse", {255'd0, frame_error}, 256'd0);

    // Overlong data frame, then back-to-back valid interest
    open_frame();
    send_seq(8'h00, 1, 1'b0);
    send_seq(8'h40, 33, 1'b0);
    check("long_no_early_err", {255'd0, frame_error}, 256'd0);
    close_frame();
    check("long_err",  {255'd0, frame_error}, 256'd1);
    check("long_rx",   {255'd0, rx_valid}, 256'd0);
    check("long_data", data, Data1);
    open_frame();
    check("b2b_err_pulse", {255'd0, frame_error}, 256'd0);
    send_seq(8'h48, 1, 1'b0);
    send_seq(8'h11, 8, 1'b0);
    close_frame();
    check("b2b_rx",     {255'd0, rx_valid}, 256'd1);
    check("b2b_prefix", {192'd0, prefix}, {192'd0, Pfx2});
    @(negedge clk);

    // Last byte coincident with ss rise
    open_frame();
    send_seq(8'h48, 1, 1'b0);
    send_seq(8'h21, 8, 1'b1);
    check("coin_rx",     {255'd0, rx_valid}, 256'd1);
    check("coin_err",    {255'd0, frame_error}, 256'd0);
    check("coin_prefix", {192'd0, prefix}, {192'd0, Pfx3});
    check("coin_data",   data, Data1);
    @(negedge clk);

    // Reset mid-frame; the still-open frame is ignored
    open_frame();
    send_seq(8'h48, 1, 1'b0);
    send_seq(8'h31, 4, 1'b0);
    rst = 1'b1;
    #1;
    check("mrst_rx",     {255'd0, rx_valid}, 256'd0);
    check("mrst_err",    {255'd0, frame_error}, 256'd0);
    check("mrst_meta",   {248'd0, meta}, 256'd0);
    check("mrst_prefix", {192'd0, prefix}, 256'd0);
    check("mrst_data",   data, 256'd0);
    @(negedge clk);
    rst = 1'b0;
    send_seq(8'h35, 4, 1'b0);
    close_frame();
    check("mrst_close_rx",  {255'd0, rx_valid}, 256'd0);
    check("mrst_close_err", {255'd0, frame_error}, 256'd0);
    @(negedge clk);
    check("mrst_after_rx",  {255'd0, rx_valid}, 256'd0);
    check("mrst_after_err", {255'd0, frame_error}, 256'd0);
    open_frame();
    send_seq(8'h48, 1, 1'b0);
    send_seq(8'h01, 8, 1'b0);
    close_frame();
    check("fresh_rx",     {255'd0, rx_valid}, 256'd1);
    check("fresh_prefix", {192'd0, prefix}, {192'd0, Pfx1});
    check("fresh_data",   data, 256'd0);
    @(negedge clk);

    // Meta length field 12 exceeds the 8-byte prefix
    open_frame();
    send_seq(8'h4C, 1, 1'b0);
    send_seq(8'h11, 8, 1'b0);
    close_frame();
`ifdef MCU_ASM_LEN_CHECK_EN
    check("len_err",    {255'd0, frame_error}, 256'd1);
    check("len_rx",     {255'd0, rx_valid}, 256'd0);
    check("len_meta",   {248'd0, meta}, 256'h48);
    check("len_prefix", {192'd0, prefix}, {192'd0, Pfx1});
`else
    check("len_err",    {255'd0, frame_error}, 256'd0);
    check("len_rx",     {255'd0, rx_valid}, 256'd1);
    check("len_meta",   {248'd0, meta}, 256'h4C);
    check("len_prefix", {192'd0, prefix}, {192'd0, Pfx2});
`endif
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mcu_packet_assembler.md
# mcu_packet_assembler

Assembles the byte stream recovered by the MCU-side SPI slave shifter into complete NDN packets. Consumes one byte per `byte_valid` pulse while the frame is open (`ss` low), classifies the packet from its first byte, shifts prefix or payload bytes MSB-first into shadow registers, and on a correctly sized frame publishes the packet fields with a one-cycle `RX_valid` pulse. Sits directly downstream of the SPI bit shifter and upstream of the NDN forwarding logic.

## Interface
Parameters:
- `PREFIX_BYTES`, 8, prefix bytes in an interest packet (64-bit prefix)
- `DATA_BYTES`, 32, payload bytes in a data packet (256-bit payload)

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `ss`  in  1  frame select, active low, already synchronous to `clk`
- `byte_in`  in  8  received byte, valid only with `byte_valid`
- `byte_valid`  in  1  one-cycle strobe per received byte
- `RX_valid`  out  1  one-cycle pulse: published fields are a new packet
- `packet_meta_data`  out  8  first byte of packet (bit 6 = type, 1 interest / 0 data; bits 5:0 = prefix length in bytes)
- `packet_prefix`  out  64  interest prefix, first received byte in bits 63:56
- `packet_data`  out  256  data payload, first received byte in bits 255:248
- `frame_error`  out  1  one-cycle pulse: frame discarded

## Operation
- States: IDLE, HDR, BODY, ERR_WAIT.
- IDLE: `ss` high. `ss` falling → HDR, byte counter cleared.
- HDR: first `byte_valid` latches shadow meta byte; expected body length = `PREFIX_BYTES` if bit 6 = 1, else `DATA_BYTES` → BODY.
- BODY: each `byte_valid` shifts `byte_in` into the shadow prefix (interest) or shadow payload (data) register from the LSB end (left shift by 8), counter +1. Counter is 6 bits, saturates; never wraps.
- Frame close (`ss` rising) in HDR or BODY:
  - counter == expected length → copy shadow meta/prefix/payload to outputs, pulse `RX_valid`, → IDLE. For interest, `packet_data` keeps its prior value; for data, `packet_prefix` keeps its prior value.
  - otherwise (short frame, header-only frame) → pulse `frame_error`, outputs unchanged, → IDLE.
- Byte beyond expected length in BODY → ERR_WAIT; pulse `frame_error` at the close; no `RX_valid`.
- ERR_WAIT: ignore bytes until `ss` rises, then pulse `frame_error`, → IDLE.
- `byte_valid` with `ss` high: ignored.
- `ss` rise and `byte_valid` in the same cycle: byte is counted first, then the close is evaluated with the updated count.
- Bit 7 of the meta byte is stored but not interpreted.

## Timing
- Reset: `RX_valid`=0, `frame_error`=0, `packet_meta_data`=0, `packet_prefix`=0, `packet_data`=0, shadows and counter 0, state IDLE.
- `RX_valid` / `frame_error` assert in the cycle after the edge where `ss` is sampled high, and are never asserted together.
- Output fields change only in the cycle `RX_valid` asserts and are stable for at least the following cycle.
- Back-to-back frames: `ss` may fall in the cycle after it rises; the new frame is accepted.
- Reset asserted mid-frame: everything returns to reset values immediately. After release, a frame already open (`ss` low) is ignored until `ss` rises.

## Configuration
- `MCU_ASM_LEN_CHECK_EN` defined: an interest packet whose meta bits 5:0 exceed `PREFIX_BYTES` or equal 0 is rejected with `frame_error` at the close, even if the byte count is correct.
- Not defined: meta bits 5:0 are passed through unchecked.

## Test plan
- Interest frame: 0x48 then 0x01..0x08, `ss` rises → `RX_valid` one cycle, meta=0x48, prefix=0x0102030405060708, `packet_data` unchanged.
- Data frame: 0x00 then 0x00..0x1F → `RX_valid`, `packet_data`[255:248]=0x00, [7:0]=0x1F, prefix unchanged.
- Short interest, 0x48 plus 5 bytes, then close → `frame_error` pulse, no `RX_valid`, outputs keep previous packet.
- Overlong data frame of 34 bytes → `frame_error` at close only; back-to-back valid interest in the next frame → `RX_valid`.
- Last byte coincident with `ss` rise on a correct interest frame → `RX_valid`; `rst` pulsed after the 4th body byte → all outputs 0, no pulses until a fresh frame.
- With `MCU_ASM_LEN_CHECK_EN`: interest meta 0x4C (length 12) with 8 body bytes → `frame_error`. Without the macro, the same frame → `RX_valid`.
